// File: rtl/issue_stage.sv
// Operand-issue register in front of the ALU: captures a decoded instruction, forwards from EX/MEM/WB,
// stalls on load-use and pending MEM data, supports flush. Define ISSUE_PERF_CNT_EN for issue/stall counters.
module issue_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   in_pc_i,
    input  logic [XLEN-1:0]   in_imm_i,
    input  logic [REG_AW-1:0] in_rs1_addr_i,
    input  logic [REG_AW-1:0] in_rs2_addr_i,
    input  logic [XLEN-1:0]   in_rs1_data_i,
    input  logic [XLEN-1:0]   in_rs2_data_i,
    input  logic [1:0]        in_a_sel_i,
    input  logic              in_b_sel_i,
    input  logic [3:0]        in_alu_func_i,
    input  logic [REG_AW-1:0] in_rd_addr_i,
    input  logic              in_rd_we_i,
    input  logic              in_is_load_i,
    input  logic [XLEN-1:0]   alu_res_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic              mem_rd_we_i,
    input  logic              mem_fwd_valid_i,
    input  logic [XLEN-1:0]   mem_fwd_data_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic              wb_rd_we_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   opr_a_o,
    output logic [XLEN-1:0]   opr_b_o,
    output logic [3:0]        alu_func_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              rd_we_o,
    output logic              is_load_o
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [63:0]       issue_cnt_o,
    output logic [63:0]       stall_cnt_o
`endif
);

    localparam logic [3:0] OP_ADD = 4'h0;

    typedef enum logic [1:0] {SRC_RF, SRC_EX, SRC_MEM, SRC_WB} fwd_src_e;

    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   opr_a_q, opr_a_d, opr_b_q, opr_b_d, store_data_q, store_data_d;
    logic [3:0]        alu_func_q, alu_func_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic              rd_we_q, rd_we_d, is_load_q, is_load_d;

    logic              advance, capture, hazard, load_use, mem_pending;
    logic              rs1_used, rs2_used, ex_fwd_ok, load_held;
    fwd_src_e          rs1_src, rs2_src;
    logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

    // Register x0 never matches a producer, so it always resolves to SRC_RF and reads as zero.
    function automatic fwd_src_e pick_src(input logic [REG_AW-1:0] rs, input logic ex_ok,
                                          input logic [REG_AW-1:0] ex_rd, input logic mem_we,
                                          input logic [REG_AW-1:0] mem_rd, input logic wb_we,
                                          input logic [REG_AW-1:0] wb_rd);
        if (rs == '0)                 return SRC_RF;
        if (ex_ok && ex_rd == rs)     return SRC_EX;
        if (mem_we && mem_rd == rs)   return SRC_MEM;
        if (wb_we && wb_rd == rs)     return SRC_WB;
        return SRC_RF;
    endfunction

    function automatic logic [XLEN-1:0] fwd_value(input fwd_src_e src, input logic [REG_AW-1:0] rs,
                                                  input logic [XLEN-1:0] rf, input logic [XLEN-1:0] ex,
                                                  input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
        case (src)
            SRC_EX:  return ex;
            SRC_MEM: return mem;
            SRC_WB:  return wb;
            default: return (rs == '0) ? '0 : rf;
        endcase
    endfunction

    assign ex_fwd_ok = out_valid_q && rd_we_q && !is_load_q;
    assign load_held = out_valid_q && is_load_q && rd_we_q;
    assign rs1_used  = (in_a_sel_i == 2'b00);
    assign rs2_used  = !in_b_sel_i || !in_rd_we_i;

    assign rs1_src = pick_src(in_rs1_addr_i, ex_fwd_ok, rd_addr_q, mem_rd_we_i, mem_rd_addr_i,
                              wb_rd_we_i, wb_rd_addr_i);
    assign rs2_src = pick_src(in_rs2_addr_i, ex_fwd_ok, rd_addr_q, mem_rd_we_i, mem_rd_addr_i,
                              wb_rd_we_i, wb_rd_addr_i);
    assign rs1_fwd = fwd_value(rs1_src, in_rs1_addr_i, in_rs1_data_i, alu_res_i, mem_fwd_data_i, wb_data_i);
    assign rs2_fwd = fwd_value(rs2_src, in_rs2_addr_i, in_rs2_data_i, alu_res_i, mem_fwd_data_i, wb_data_i);

    assign load_use = load_held &&
                      ((rs1_used && in_rs1_addr_i != '0 && rd_addr_q == in_rs1_addr_i) ||
                       (rs2_used && in_rs2_addr_i != '0 && rd_addr_q == in_rs2_addr_i));
    assign mem_pending = !mem_fwd_valid_i && (rs1_src == SRC_MEM || rs2_src == SRC_MEM);
    assign hazard      = load_use || mem_pending;

    assign advance    = !out_valid_q || out_ready_i;
    // Flush consumes and drops the upstream beat, so it must still report ready.
    assign in_ready_o = flush_i || (advance && !hazard);
    assign capture    = in_valid_i && in_ready_o && !flush_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        out_valid_d  = out_valid_q;
        opr_a_d      = opr_a_q;
        opr_b_d      = opr_b_q;
        alu_func_d   = alu_func_q;
        store_data_d = store_data_q;
        rd_addr_d    = rd_addr_q;
        rd_we_d      = rd_we_q;
        is_load_d    = is_load_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d = capture;
        end
        if (capture) begin
            case (in_a_sel_i)
                2'b00:   opr_a_d = rs1_fwd;
                2'b01:   opr_a_d = in_pc_i;
                default: opr_a_d = '0;
            endcase
            opr_b_d      = in_b_sel_i ? in_imm_i : rs2_fwd;
            store_data_d = rs2_fwd;
            alu_func_d   = in_alu_func_i;
            rd_addr_d    = in_rd_addr_i;
            rd_we_d      = in_rd_we_i;
            is_load_d    = in_is_load_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            opr_a_q      <= '0;
            opr_b_q      <= '0;
            alu_func_q   <= OP_ADD;
            store_data_q <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            is_load_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            opr_a_q      <= opr_a_d;
            opr_b_q      <= opr_b_d;
            alu_func_q   <= alu_func_d;
            store_data_q <= store_data_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
            is_load_q    <= is_load_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign opr_a_o      = opr_a_q;
    assign opr_b_o      = opr_b_q;
    assign alu_func_o   = alu_func_q;
    assign store_data_o = store_data_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_we_o      = rd_we_q;
    assign is_load_o    = is_load_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [63:0] issue_cnt_q, stall_cnt_q;

    // Pure downstream backpressure is not a hazard and is not counted as a stall.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (capture)                           issue_cnt_q <= issue_cnt_q + 64'd1;
            if (in_valid_i && hazard && !flush_i) stall_cnt_q <= stall_cnt_q + 64'd1;
        end
    end

    assign issue_cnt_o = issue_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
